// File: rtl/mdu.sv
// rtl/mdu.sv - iterative multiply/divide unit with HI/LO registers
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef logic [63:0] dword_t;
endpackage

module mdu
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] port_a,
    input  logic [31:0] port_b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, next_state;

    logic [1:0] op_q;
    word_t      a_q;
    word_t      opnd_q;
    word_t      part_hi;
    word_t      part_lo;
    logic       a_neg_q;
    logic       b_neg_q;
    logic       div_zero_q;
    logic [4:0] cnt;
    logic       last;

    logic       signed_in;
    logic       a_neg_in;
    logic       b_neg_in;
    word_t      a_mag_in;
    word_t      b_mag_in;

    logic [32:0] mul_sum;
    logic [32:0] div_r;
    logic [32:0] div_diff;
    word_t       nxt_hi;
    word_t       nxt_lo;
    dword_t      prod;
    logic        res_neg;
    word_t       fin_hi;
    word_t       fin_lo;

    assign last = (cnt == 5'd31);

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and status outputs; busy/done decode straight from the state
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (last) begin
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Operand magnitudes at start; signed ops iterate on absolute values
    always_comb begin
        signed_in = ~op[0];
        a_neg_in  = signed_in & port_a[31];
        b_neg_in  = signed_in & port_b[31];
        a_mag_in  = a_neg_in ? (~port_a + 32'd1) : port_a;
        b_mag_in  = b_neg_in ? (~port_b + 32'd1) : port_b;
    end

    // One iteration step: shift-add multiply or restoring divide
    always_comb begin
        mul_sum  = {1'b0, part_hi} + (part_lo[0] ? {1'b0, opnd_q} : 33'd0);
        div_r    = {part_hi, part_lo[31]};
        // bit 32 of the difference is the borrow: the partial remainder is
        // always below twice the divisor, so a non-negative result fits 32 bits
        div_diff = div_r - {1'b0, opnd_q};
        if (!op_q[1]) begin
            nxt_hi = mul_sum[32:1];
            nxt_lo = {mul_sum[0], part_lo[31:1]};
        end else if (!div_diff[32]) begin
            nxt_hi = div_diff[31:0];
            nxt_lo = {part_lo[30:0], 1'b1};
        end else begin
            nxt_hi = div_r[31:0];
            nxt_lo = {part_lo[30:0], 1'b0};
        end
    end

    // Sign correction and special cases applied to the last step's result
    always_comb begin
        prod    = {nxt_hi, nxt_lo};
        res_neg = a_neg_q ^ b_neg_q;
        if (!op_q[1]) begin
            if (res_neg) begin
                prod = ~prod + 64'd1;
            end
            fin_hi = prod[63:32];
            fin_lo = prod[31:0];
        end else if (div_zero_q) begin
            fin_hi = a_q;
            fin_lo = 32'hFFFF_FFFF;
        end else begin
            fin_lo = res_neg ? (~nxt_lo + 32'd1) : nxt_lo;
            fin_hi = a_neg_q ? (~nxt_hi + 32'd1) : nxt_hi;
        end
    end

    // Datapath: operand latch, iteration, result write-back, MTHI/MTLO
    always_ff @(posedge CLK) begin
        if (RST) begin
            op_q       <= 2'b00;
            a_q        <= '0;
            opnd_q     <= '0;
            part_hi    <= '0;
            part_lo    <= '0;
            a_neg_q    <= 1'b0;
            b_neg_q    <= 1'b0;
            div_zero_q <= 1'b0;
            cnt        <= '0;
            hi         <= '0;
            lo         <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q       <= op;
                        a_q        <= port_a;
                        a_neg_q    <= a_neg_in;
                        b_neg_q    <= b_neg_in;
                        div_zero_q <= (port_b == 32'd0);
                        cnt        <= '0;
                        part_hi    <= '0;
                        // multiply walks multiplier bits out of part_lo;
                        // divide shifts dividend bits out of part_lo
                        part_lo    <= op[1] ? a_mag_in : b_mag_in;
                        opnd_q     <= op[1] ? b_mag_in : a_mag_in;
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                S_RUN: begin
                    part_hi <= nxt_hi;
                    part_lo <= nxt_lo;
                    cnt     <= cnt + 5'd1;
                    if (last) begin
                        hi <= fin_hi;
                        lo <= fin_lo;
                    end
                end
                S_DONE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - directed self-checking bench for mdu
module tb_mdu;

    logic        CLK;
    logic        RST;
    logic        start;
    logic [1:0]  op;
    logic [31:0] port_a;
    logic [31:0] port_b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests;
    int n_fail;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    mdu dut (
        .CLK    (CLK),
        .RST    (RST),
        .start  (start),
        .op     (op),
        .port_a (port_a),
        .port_b (port_b),
        .hi_we  (hi_we),
        .lo_we  (lo_we),
        .wdata  (wdata),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ex_hi,
                          input logic [31:0] ex_lo, input bit disturb);
        int lat;
        int busy_cnt;
        start  = 1'b1;
        op     = o;
        port_a = a;
        port_b = b;
        tick();
        start    = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            if (disturb && lat == 5) begin
                start  = 1'b1;
                op     = OP_MULTU;
                port_a = 32'h0000_0100;
                port_b = 32'h0000_0200;
                hi_we  = 1'b1;
                wdata  = 32'h0000_1234;
            end
            if (disturb && lat == 6) begin
                start = 1'b0;
                hi_we = 1'b0;
            end
            tick();
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'd32);
        check({tag, " busy_cycles"}, 64'(busy_cnt), 64'd32);
        check({tag, " hi"}, {32'd0, hi}, {32'd0, ex_hi});
        check({tag, " lo"}, {32'd0, lo}, {32'd0, ex_lo});
        tick();
        check({tag, " done_single"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        int done_seen;
        n_tests = 0;
        n_fail  = 0;
        RST     = 1'b1;
        start   = 1'b0;
        op      = 2'b00;
        port_a  = '0;
        port_b  = '0;
        hi_we   = 1'b0;
        lo_we   = 1'b0;
        wdata   = '0;
        tick();
        tick();
        RST = 1'b0;
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset hi", {32'd0, hi}, 64'd0);
        check("reset lo", {32'd0, lo}, 64'd0);

        // MTHI / MTLO in IDLE
        hi_we = 1'b1; wdata = 32'hA5A5_A5A5;
        tick();
        hi_we = 1'b0;
        check("mthi hi", {32'd0, hi}, 64'hA5A5_A5A5);
        check("mthi lo", {32'd0, lo}, 64'd0);
        lo_we = 1'b1; wdata = 32'h5A5A_5A5A;
        tick();
        lo_we = 1'b0;
        check("mtlo lo", {32'd0, lo}, 64'h5A5A_5A5A);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1111_2222;
        tick();
        hi_we = 1'b0; lo_we = 1'b0;
        check("mtboth hi", {32'd0, hi}, 64'h1111_2222);
        check("mtboth lo", {32'd0, lo}, 64'h1111_2222);

        // start together with a write: start wins, hi held during RUN
        start = 1'b1; op = OP_MULTU; port_a = 32'd2; port_b = 32'd3;
        hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
        tick();
        start = 1'b0; hi_we = 1'b0;
        check("start_we busy", {63'd0, busy}, 64'd1);
        check("start_we hi held", {32'd0, hi}, 64'h1111_2222);
        for (int i = 0; i < 40 && !done; i++) tick();
        check("start_we lo", {32'd0, lo}, 64'd6);
        tick();

        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("mult_neg3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_op("mult_minsq", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
        run_op("multu_shift", OP_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0);
        run_op("div_neg7by2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("divu_7by2", OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0);
        run_op("div_100byneg7", OP_DIV, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 1'b0);
        run_op("divu_5by0", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b0);
        run_op("div_neg5by0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
        run_op("disturbed", OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b1);

        // reset in the middle of an operation
        start = 1'b1; op = OP_MULTU; port_a = 32'hFFFF_FFFF; port_b = 32'hFFFF_FFFF;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("abort busy", {63'd0, busy}, 64'd0);
        check("abort done", {63'd0, done}, 64'd0);
        check("abort hi", {32'd0, hi}, 64'd0);
        check("abort lo", {32'd0, lo}, 64'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) done_seen++;
            tick();
        end
        check("abort no_done", 64'(done_seen), 64'd0);
        run_op("after_abort", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
